// File: rtl/sbus_sram_arbiter_pkg.sv
// Shared definitions for the sbus-to-SRAM arbiter: FSM states, parameter
// legality limits and the index-width helper.
package sbus_sram_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned N_CH_MIN    = 1;
    localparam int unsigned N_CH_MAX    = 8;
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;

    // Wide enough to hold LATENCY_MAX.
    localparam int unsigned CNT_W = 3;

    // Channel index width; a single channel still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sbus_sram_arbiter_rr_arbiter.sv
// Round-robin selector: grants the first requester strictly after the
// last-granted index, wrapping from N_CH-1 back to 0.
module rr_arbiter
    import sbus_sram_arbiter_pkg::*;
#(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_CH-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Lowest requester above the pointer wins; otherwise wrap to the lowest requester.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        gnt_o    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (req_i[i]) begin
                if (!hi_found && (i > 32'(last_i))) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
            end
        end
        idx_o = hi_found ? hi_idx : lo_idx;
        for (int unsigned i = 0; i < N_CH; i++) begin
            gnt_o[i] = lo_found && (idx_o == IDX_W'(i));
        end
    end

endmodule

// File: rtl/sbus_sram_arbiter.sv
// Arbitrates N_CH sbus masters onto one SRAM port with fixed read latency.
// One access outstanding at a time; a new access may issue in the
// completion cycle of the previous one.
module sbus_sram_arbiter
    import sbus_sram_arbiter_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [N_CH-1:0]            ch_req,
    input  logic [N_CH*DATA_W/8-1:0]   ch_wen,
    input  logic [N_CH*ADDR_W-1:0]     ch_addr,
    input  logic [N_CH*DATA_W-1:0]     ch_wdata,
    output logic [N_CH-1:0]            ch_ready,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       sram_en,
    output logic [DATA_W/8-1:0]        sram_we,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic [DATA_W-1:0]          sram_wdata,
    input  logic [DATA_W-1:0]          sram_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = idx_width(N_CH);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
        $error("sbus_sram_arbiter: N_CH out of legal range");
    end
    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("sbus_sram_arbiter: LATENCY out of legal range");
    end

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             run_q;

    logic             completion;
    logic             issue;
    logic [N_CH-1:0]  grant_oh;
    logic [N_CH-1:0]  eligible;
    logic [N_CH-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i  (eligible),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    // Completion detect, eligibility mask and issue decision.
    // run_q holds off issue until the first clock edge after reset release,
    // so outputs stay quiet while reset is asserted or just released.
    always_comb begin
        grant_oh = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            grant_oh[i] = (grant_q == IDX_W'(i));
        end
        completion = (state_q == BUSY) && (cnt_q == CNT_W'(1));
        eligible   = ch_req & ~(completion ? grant_oh : '0);
        issue      = run_q && ((state_q == IDLE) || completion) && (|eligible);
    end

    // Next-state: load on issue, count down while busy, go idle on completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (issue) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY);
            grant_d = arb_idx;
            last_d  = arb_idx;
        end else if (state_q == BUSY) begin
            if (completion) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers; pointer resets to N_CH-1 so channel 0 wins first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(N_CH - 1);
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            run_q   <= 1'b1;
        end
    end

    // SRAM request path: granted channel's fields pass straight through on issue.
    always_comb begin
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (issue && arb_gnt[i]) begin
                sram_we    = ch_wen[i*BE_W +: BE_W];
                sram_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sram_wdata = ch_wdata[i*DATA_W +: DATA_W];
            end
        end
        sram_en = issue;
    end

    // Completion response: one-cycle ready to the granted channel, read data passthrough.
    always_comb begin
        ch_ready = completion ? grant_oh : '0;
        ch_rdata = completion ? sram_rdata : '0;
    end

endmodule

// File: doc/sbus_sram_arbiter.md
SBUS_SRAM_ARBITER -- requirements
Module: sbus_sram_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of sbus master channels (legal 1..8).
REQ-002 SHALL have parameter LATENCY, default 1: SRAM read latency in cycles (legal 1..4).
REQ-003 SHALL have parameter ADDR_W, default 32: address width.
REQ-004 SHALL have parameter DATA_W, default 32: data width (multiple of 8).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port ch_req  input  N_CH  per-channel request, held high until ch_ready.
REQ-008 SHALL have port ch_wen  input  N_CH*DATA_W/8  per-channel byte write enables; all-zero means read.
REQ-009 SHALL have port ch_addr  input  N_CH*ADDR_W  per-channel address.
REQ-010 SHALL have port ch_wdata  input  N_CH*DATA_W  per-channel write data.
REQ-011 SHALL have port ch_ready  output  N_CH  one-cycle completion pulse per channel.
REQ-012 SHALL have port ch_rdata  output  DATA_W  read data broadcast to all channels, valid only with ch_ready.
REQ-013 SHALL have port sram_en  output  1  SRAM access strobe.
REQ-014 SHALL have port sram_we  output  DATA_W/8  SRAM byte write enables.
REQ-015 SHALL have port sram_addr  output  ADDR_W  SRAM address.
REQ-016 SHALL have port sram_wdata  output  DATA_W  SRAM write data.
REQ-017 SHALL have port sram_rdata  input  DATA_W  SRAM read data, valid LATENCY cycles after the sram_en cycle.

Function
REQ-018 SHALL have states IDLE (no access outstanding) and BUSY (one access outstanding).
REQ-019 SHALL, in any cycle where arbitration is allowed and at least one eligible ch_req is high, drive sram_en=1 plus that channel's wen/addr/wdata combinationally from the channel inputs, latch the grant index, load a latency counter with LATENCY, and enter BUSY.
REQ-020 SHALL allow arbitration in IDLE and in the completion cycle of BUSY.
REQ-021 SHALL drive sram_en=0, sram_we=0, sram_addr=0 and sram_wdata=0 in every cycle without an issue.
REQ-022 SHALL decrement the counter each BUSY cycle; the completion cycle is the cycle the counter reads 1, exactly LATENCY cycles after the issue cycle.
REQ-023 SHALL, in the completion cycle, pulse ch_ready[grant]=1 for one cycle and pass ch_rdata=sram_rdata combinationally.
REQ-024 SHALL then return to IDLE, or stay in BUSY with a new grant if a new issue occurs in the completion cycle (one access per cycle throughput when LATENCY=1).
REQ-025 SHALL treat reads and writes identically for timing; ch_rdata content on write completion is don't-care.
REQ-026 SHALL arbitrate round-robin: grant the first requesting channel after the last-granted index, wrapping from N_CH-1 to 0.
REQ-027 SHALL exclude the completing channel from arbitration in its completion cycle, even if its ch_req is still high.
REQ-028 SHALL complete a granted access and pulse ch_ready even if ch_req drops mid-access; no abort.
REQ-029 SHALL keep ch_ready=0 on all non-granted channels and never pulse more than one ch_ready per cycle.
REQ-030 SHALL, with N_CH=1, degenerate to a single-channel bridge with identical timing.

Reset
REQ-031 SHALL, on resetn low, asynchronously enter IDLE, clear the counter, set ch_ready=0, and set the last-granted pointer to N_CH-1 so that channel 0 wins first.
REQ-032 SHALL drop an access in flight at reset without a ch_ready pulse; the first issue after reset release occurs no earlier than the first rising edge with resetn high.

Structure
REQ-033 SHALL place the state enum and the LATENCY/N_CH legality limits in the shared includes package.
REQ-034 SHALL implement the round-robin selector as sub-module rr_arbiter (inputs: request vector, last pointer; outputs: one-hot grant, index).

Verification
REQ-035 SHALL cover this reset scenario: after reset, ch_req=2'b11 with LATENCY=1 -> channel 0 issues first, channel 1 next cycle, ch_ready[0] and ch_ready[1] pulse on consecutive cycles.
REQ-036 SHALL cover this read scenario: LATENCY=3, channel 1 reads addr 0x1000 with SRAM returning 0xDEADBEEF -> sram_en high 1 cycle, ch_ready[1] and ch_rdata=0xDEADBEEF exactly 3 cycles later.
REQ-037 SHALL cover this write scenario: channel 0 writes wen=4'b0011, addr 0x20, wdata 0x12345678 -> sram_we=4'b0011, sram_addr=0x20, sram_wdata=0x12345678 in the issue cycle; ch_ready[0] after LATENCY.
REQ-038 SHALL cover this fairness scenario: N_CH=4, all channels requesting continuously -> grant order 0,1,2,3,0 with no channel granted twice within 4 issues.
REQ-039 SHALL cover this single-master scenario: one channel requesting continuously with LATENCY=1 -> that channel is not re-granted in its own completion cycle, so sram_en alternates 1,0.
REQ-040 SHALL cover this mid-access reset scenario: resetn low during BUSY with LATENCY=4 -> all outputs zero immediately, no ch_ready, and channel 0 wins first after release.
